// File: rtl/spi_mosi_miso_if.sv
// Signal bundle between the SPI register file (master) and the bit-serial data engine (slave).
// Carries the start/ready handshakes, the parallel words and the two serial lines.
interface spi_mosi_miso_if #(
  parameter int unsigned WIDTH = 32
);
  logic             transmit_ready;
  logic [WIDTH-1:0] mosi_data;
  logic             transmit_start;
  logic             mosi_out;
  logic             receive_ready;
  logic [WIDTH-1:0] miso_data;
  logic             receive_start;
  logic             miso_in;

  modport master (
    input  transmit_ready,
    input  mosi_out,
    input  receive_ready,
    input  miso_data,
    output mosi_data,
    output transmit_start,
    output receive_start,
    output miso_in
  );

  modport slave (
    output transmit_ready,
    output mosi_out,
    output receive_ready,
    output miso_data,
    input  mosi_data,
    input  transmit_start,
    input  receive_start,
    input  miso_in
  );
endinterface

// File: rtl/spi_mosi_miso.sv
// Bit-serial SPI data engine: independent MOSI (word -> MSB-first bits) and MISO
// (MSB-first bits -> word) channels, one bit per clk cycle.
module spi_mosi_miso #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  spi_mosi_miso_if.slave bus
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic {StIdle, StShift} state_e;

  // ---------------------------------------------------------------------------
  // MOSI channel
  // ---------------------------------------------------------------------------
  state_e           tx_state_q, tx_state_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [CntW-1:0]  tx_cnt_q, tx_cnt_d;
  logic             mosi_out_q, mosi_out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      mosi_out_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      mosi_out_q <= mosi_out_d;
    end
  end

  // The shift register's MSB is always the bit on the wire while shifting.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    case (tx_state_q)
      StIdle: begin
        if (bus.transmit_start) begin
          tx_state_d = StShift;
          tx_shift_d = bus.mosi_data;
          tx_cnt_d   = '0;
        end
      end
      StShift: begin
        if (tx_cnt_q == LastBit) begin
          tx_state_d = StIdle;
          tx_shift_d = '0;
          tx_cnt_d   = '0;
        end else begin
          tx_shift_d = tx_shift_q << 1;
          tx_cnt_d   = tx_cnt_q + CntOne;
        end
      end
      default: begin
        tx_state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    mosi_out_d         = (tx_state_d == StShift) ? tx_shift_d[WIDTH-1] : 1'b0;
    bus.mosi_out       = mosi_out_q;
    bus.transmit_ready = (tx_state_q == StIdle);
  end

  // ---------------------------------------------------------------------------
  // MISO channel
  // ---------------------------------------------------------------------------
  state_e           rx_state_q, rx_state_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_word_q, rx_word_d;
  logic [CntW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [WIDTH-1:0] rx_shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= StIdle;
      rx_shift_q <= '0;
      rx_word_q  <= '0;
      rx_cnt_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_word_q  <= rx_word_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  assign rx_shifted = (rx_shift_q << 1) | WIDTH'(bus.miso_in);

  // The visible word is only replaced on the final sample, never with a partial word.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_word_d  = rx_word_q;
    rx_cnt_d   = rx_cnt_q;
    case (rx_state_q)
      StIdle: begin
        if (bus.receive_start) begin
          rx_state_d = StShift;
          rx_shift_d = '0;
          rx_cnt_d   = '0;
        end
      end
      StShift: begin
        if (rx_cnt_q == LastBit) begin
          rx_state_d = StIdle;
          rx_word_d  = rx_shifted;
          rx_shift_d = '0;
          rx_cnt_d   = '0;
        end else begin
          rx_shift_d = rx_shifted;
          rx_cnt_d   = rx_cnt_q + CntOne;
        end
      end
      default: begin
        rx_state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.receive_ready = (rx_state_q == StIdle);
    bus.miso_data     = rx_word_q;
  end

endmodule

// File: tb/tb_spi_mosi_miso.sv
// Self-checking bench for spi_mosi_miso: directed scenarios plus randomized traffic,
// all compared each cycle against a queue-based reference model.
module tb_spi_mosi_miso;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_mosi_miso_if #(.WIDTH(W)) bus ();

  spi_mosi_miso #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: tx_q holds the bits still to appear on mosi_out (head = current bit).
  bit             tx_q[$];
  bit             rx_q[$];
  bit             rx_busy;
  logic [W-1:0]   exp_miso;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    rx_busy  = 1'b0;
    exp_miso = '0;
  endtask

  task automatic model_edge();
    if (tx_q.size() == 0) begin
      if (bus.transmit_start) begin
        for (int i = W - 1; i >= 0; i--) tx_q.push_back(bus.mosi_data[i]);
      end
    end else begin
      void'(tx_q.pop_front());
    end
    if (rx_busy) begin
      rx_q.push_back(bus.miso_in);
      if (rx_q.size() == W) begin
        for (int i = 0; i < W; i++) exp_miso[W-1-i] = rx_q[i];
        rx_q.delete();
        rx_busy = 1'b0;
      end
    end else if (bus.receive_start) begin
      rx_busy = 1'b1;
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic exp_bit;
    exp_bit = (tx_q.size() == 0) ? 1'b0 : tx_q[0];
    check_eq({ctx, ".transmit_ready"}, W'(bus.transmit_ready), W'(tx_q.size() == 0));
    check_eq({ctx, ".mosi_out"}, W'(bus.mosi_out), W'(exp_bit));
    check_eq({ctx, ".receive_ready"}, W'(bus.receive_ready), W'(!rx_busy));
    check_eq({ctx, ".miso_data"}, bus.miso_data, exp_miso);
  endtask

  task automatic tick(input string ctx);
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_outputs(ctx);
  endtask

  task automatic idle_inputs();
    bus.transmit_start = 1'b0;
    bus.receive_start  = 1'b0;
    bus.mosi_data      = $urandom();
    bus.miso_in        = 1'($urandom_range(0, 1));
  endtask

  logic [W-1:0] cap;
  logic [W-1:0] word;
  int           low_cnt;

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    check_outputs("reset_async");
    tick("reset");
    tick("reset");
    check_eq("reset.miso_data", bus.miso_data, '0);
    check_eq("reset.mosi_out", W'(bus.mosi_out), '0);
    rst = 1'b0;
    tick("post_reset");

    // MOSI word, capture bits and count busy cycles
    bus.mosi_data      = 32'hA5C3_0F81;
    bus.transmit_start = 1'b1;
    tick("mosi_word");
    idle_inputs();
    cap     = W'(bus.mosi_out);
    low_cnt = bus.transmit_ready ? 0 : 1;
    for (int k = 1; k < W; k++) begin
      tick("mosi_word");
      cap = {cap[W-2:0], bus.mosi_out};
      if (!bus.transmit_ready) low_cnt++;
    end
    tick("mosi_word_end");
    check_eq("mosi_word.capture", cap, 32'hA5C3_0F81);
    check_eq("mosi_word.busy_cycles", W'(low_cnt), W'(32));
    check_eq("mosi_word.ready_after", W'(bus.transmit_ready), W'(1));

    // MISO word
    word              = 32'hDEAD_BEEF;
    bus.receive_start = 1'b1;
    tick("miso_word");
    bus.receive_start = 1'b0;
    for (int k = 0; k < W; k++) begin
      bus.miso_in = word[W-1-k];
      tick("miso_word");
    end
    check_eq("miso_word.data", bus.miso_data, 32'hDEAD_BEEF);
    check_eq("miso_word.ready", W'(bus.receive_ready), W'(1));

    // Busy start ignored
    bus.mosi_data      = 32'hFFFF_FFFF;
    bus.transmit_start = 1'b1;
    tick("busy");
    idle_inputs();
    cap = W'(bus.mosi_out);
    for (int k = 1; k < W; k++) begin
      if (k == 10) begin
        bus.transmit_start = 1'b1;
        bus.mosi_data      = '0;
      end else begin
        idle_inputs();
      end
      tick("busy");
      cap = {cap[W-2:0], bus.mosi_out};
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) tick("busy_after");
    check_eq("busy.capture", cap, 32'hFFFF_FFFF);
    check_eq("busy.no_second", W'({bus.transmit_ready, bus.mosi_out}), W'(2'b10));

    // Concurrent channels on the same edge
    word               = 32'h8765_4321;
    bus.mosi_data      = 32'h1234_5678;
    bus.transmit_start = 1'b1;
    bus.receive_start  = 1'b1;
    tick("concurrent");
    bus.transmit_start = 1'b0;
    bus.receive_start  = 1'b0;
    cap = W'(bus.mosi_out);
    for (int k = 0; k < W; k++) begin
      bus.miso_in = word[W-1-k];
      tick("concurrent");
      if (k < W - 1) cap = {cap[W-2:0], bus.mosi_out};
    end
    check_eq("concurrent.mosi", cap, 32'h1234_5678);
    check_eq("concurrent.miso", bus.miso_data, 32'h8765_4321);
    tick("concurrent_end");

    // Reset at bit 12 of a reception, with starts asserted during reset
    bus.receive_start = 1'b1;
    tick("rst_mid");
    bus.receive_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.miso_in = 1'($urandom_range(0, 1));
      tick("rst_mid");
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_mid_async");
    check_eq("rst_mid.miso_data", bus.miso_data, '0);
    check_eq("rst_mid.receive_ready", W'(bus.receive_ready), W'(1));
    bus.receive_start  = 1'b1;
    bus.transmit_start = 1'b1;
    tick("rst_wins");
    bus.receive_start  = 1'b0;
    bus.transmit_start = 1'b0;
    rst = 1'b0;
    tick("rst_release");
    word              = 32'h0000_0001;
    bus.receive_start = 1'b1;
    tick("rst_fresh");
    bus.receive_start = 1'b0;
    for (int k = 0; k < W; k++) begin
      bus.miso_in = word[W-1-k];
      tick("rst_fresh");
    end
    check_eq("rst_fresh.miso_data", bus.miso_data, 32'h0000_0001);

    // Starts held high retrigger as soon as each channel frees up
    bus.transmit_start = 1'b1;
    bus.receive_start  = 1'b1;
    for (int c = 0; c < 80; c++) begin
      bus.mosi_data = $urandom();
      bus.miso_in   = 1'($urandom_range(0, 1));
      tick("held");
    end

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 1500; c++) begin
      bus.transmit_start = ($urandom_range(0, 3) == 0);
      bus.receive_start  = ($urandom_range(0, 3) == 0);
      bus.mosi_data      = $urandom();
      bus.miso_in        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rand_rst");
        tick("rand_rst");
        rst = 1'b0;
      end
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
